// File: rtl/nested_update_bank_if.sv
// nested_update_bank_if: control/data bundle for nested_update_bank.
//   master : drives en, load_dflt, cond1, cond2, data_in; observes outputs
//   slave  : the bank; drives data_out (CHANNELS*WIDTH), locked, streak
// STREAK_W must equal $clog2(LOCK_CYCLES+1) (minimum 1) of the attached bank.
interface nested_update_bank_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned STREAK_W = 3
);
  logic                         en;
  logic                         load_dflt;
  logic                         cond1;
  logic                         cond2;
  logic [WIDTH-1:0]             data_in;
  logic [CHANNELS*WIDTH-1:0]    data_out;
  logic                         locked;
  logic [STREAK_W-1:0]          streak;

  modport master (
    output en, load_dflt, cond1, cond2, data_in,
    input  data_out, locked, streak
  );

  modport slave (
    input  en, load_dflt, cond1, cond2, data_in,
    output data_out, locked, streak
  );
endinterface

// File: rtl/nested_update_bank.sv
// nested_update_bank: multi-channel register bank with nested-priority updates.
// Channel k (scale k+1) loads data_in +/- a scaled offset chosen by cond1/cond2;
// a run of LOCK_CYCLES consecutive top-priority updates freezes the bank (LOCK)
// until cond1 drops. load_dflt loads scaled defaults from any state.
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   bus      nested_update_bank_if.slave (en, load_dflt, cond1, cond2, data_in,
//            data_out, locked, streak); channel k at data_out[k*WIDTH +: WIDTH]
// Build option: define NESTED_SAT_EN for clamping arithmetic instead of wrap.
module nested_update_bank #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned OFF1        = 10,
  parameter int unsigned OFF2        = 100,
  parameter int unsigned DFLT        = 'h11,
  parameter int unsigned LOCK_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nested_update_bank_if.slave  bus
);

  localparam int unsigned SW = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
  // Wide enough to hold any scaled offset plus data without overflow.
  localparam int unsigned OW = WIDTH + $clog2(CHANNELS) + 8;
  localparam logic [WIDTH-1:0] MAXV   = {WIDTH{1'b1}};
  localparam logic [SW-1:0]    LOCK_N = SW'(LOCK_CYCLES);

  typedef enum logic {RUN = 1'b0, LOCK = 1'b1} state_t;

  state_t                          state_q, state_d;
  logic [SW-1:0]                   streak_q, streak_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  regs_q, regs_d;
  logic [CHANNELS-1:0][WIDTH-1:0]  val_a2, val_a1, val_a0, val_df;

  function automatic logic [WIDTH-1:0] add_off(input logic [WIDTH-1:0] d,
                                               input logic [OW-1:0] a);
    logic [OW-1:0] s;
    s = OW'(d) + a;
`ifdef NESTED_SAT_EN
    return (s > OW'(MAXV)) ? MAXV : WIDTH'(s);
`else
    return WIDTH'(s);
`endif
  endfunction

  function automatic logic [WIDTH-1:0] sub_off(input logic [WIDTH-1:0] d,
                                               input logic [OW-1:0] a);
    logic [OW-1:0] s;
    s = OW'(d) - a;
`ifdef NESTED_SAT_EN
    return (a > OW'(d)) ? '0 : WIDTH'(s);
`else
    return WIDTH'(s);
`endif
  endfunction

  // Per-channel candidate values for each update branch.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    localparam logic [OW-1:0] A1 = OW'(OFF1 * (k + 1));
    localparam logic [OW-1:0] A2 = OW'(OFF2 * (k + 1));
    assign val_a2[k] = add_off(bus.data_in, A2);
    assign val_a1[k] = add_off(bus.data_in, A1);
    assign val_a0[k] = sub_off(bus.data_in, A1);
    // Defaults always wrap, even with clamping arithmetic enabled.
    assign val_df[k] = WIDTH'(DFLT * (k + 1));
  end

  // Next-state / next-value decode in priority order.
  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    regs_d   = regs_q;
    if (bus.load_dflt) begin
      regs_d   = val_df;
      streak_d = '0;
      state_d  = RUN;
    end else if (state_q == LOCK) begin
      if (!bus.cond1) begin
        state_d  = RUN;
        streak_d = '0;
      end
    end else if (bus.en) begin
      if (bus.cond1 && bus.cond2) begin
        regs_d   = val_a2;
        streak_d = (streak_q >= LOCK_N) ? streak_q : streak_q + SW'(1);
        if ((LOCK_CYCLES != 0) && (streak_d == LOCK_N)) begin
          state_d = LOCK;
        end
      end else if (bus.cond1) begin
        regs_d   = val_a1;
        streak_d = '0;
      end else begin
        regs_d   = val_a0;
        streak_d = '0;
      end
    end
  end

  // State and register bank.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= RUN;
      streak_q <= '0;
      regs_q   <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      regs_q   <= regs_d;
    end
  end

  assign bus.data_out = regs_q;
  assign bus.locked   = (state_q == LOCK);
  assign bus.streak   = streak_q;

endmodule

// File: tb/tb_nested_update_bank.sv
// tb_nested_update_bank: directed vector table plus a hand-written LOCK
// hold/exit sequence for nested_update_bank (WIDTH=8, CHANNELS=2).
module tb_nested_update_bank;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  nested_update_bank_if #(.WIDTH(8), .CHANNELS(2), .STREAK_W(3)) bus ();

  nested_update_bank #(
    .WIDTH(8), .CHANNELS(2), .OFF1(10), .OFF2(100), .DFLT('h11), .LOCK_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        ld;
    logic        c1;
    logic        c2;
    logic [7:0]  din;
    logic [15:0] dout;
    logic        lk;
    logic [2:0]  stk;
  } vec_t;

  vec_t vecs[$];
  int   errors = 0;
  int   checks = 0;

`ifdef NESTED_SAT_EN
  localparam logic [15:0] E_ELSE = 16'h0000;
  localparam logic [15:0] E_TOP  = 16'hFFE4;
`else
  localparam logic [15:0] E_ELSE = 16'hF1FB;
  localparam logic [15:0] E_TOP  = 16'h48E4;
`endif

  function automatic vec_t mk(logic r, logic e, logic l, logic a, logic b,
                              logic [7:0] d, logic [15:0] o, logic k,
                              logic [2:0] s);
    vec_t v;
    v.rst_n = r; v.en = e; v.ld = l; v.c1 = a; v.c2 = b; v.din = d;
    v.dout = o; v.lk = k; v.stk = s;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock once, sample just after the edge.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic a, input logic b, input logic [7:0] d);
    reset_n       = r;
    bus.en        = e;
    bus.load_dflt = l;
    bus.cond1     = a;
    bus.cond2     = b;
    bus.data_in   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; bus.en = 1'b0; bus.load_dflt = 1'b0;
    bus.cond1 = 1'b0; bus.cond2 = 1'b0; bus.data_in = '0;
    #1;

    //                rst en ld c1 c2 din    dout        lk stk
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h55, 16'h0000, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 0, 8'h55, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 8'h05, E_ELSE,   0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 8'h30, 16'h443A, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h80, E_TOP,    0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00, 16'h140A, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h01, 16'hC965, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h02, 16'hCA66, 0, 2));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h03, 16'hCB67, 0, 3));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h04, 16'hCC68, 1, 4));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h20, 16'hCC68, 1, 4));
    vecs.push_back(mk(1, 1, 0, 0, 1, 8'h20, 16'hCC68, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0, 8'h20, 16'h0C16, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 1, 8'h77, 16'h0C16, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h77, 16'h0C16, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h10, 16'hD874, 0, 1));
    vecs.push_back(mk(1, 0, 0, 1, 1, 8'h99, 16'hD874, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h11, 16'hD975, 0, 2));
    vecs.push_back(mk(1, 0, 0, 1, 0, 8'h99, 16'hD975, 0, 2));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h12, 16'hDA76, 0, 3));
    vecs.push_back(mk(1, 0, 0, 0, 0, 8'h99, 16'hDA76, 0, 3));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h13, 16'hDB77, 1, 4));
    vecs.push_back(mk(1, 1, 1, 1, 1, 8'h13, 16'h2211, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h00, 16'hC864, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 0, 8'h00, 16'h140A, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h00, 16'hC864, 0, 1));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h00, 16'hC864, 0, 2));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h00, 16'hC864, 0, 3));
    vecs.push_back(mk(1, 1, 0, 1, 1, 8'h00, 16'hC864, 1, 4));
    vecs.push_back(mk(0, 1, 0, 1, 1, 8'h00, 16'h0000, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 8'h00, 16'h2211, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 8'h00, 16'h0000, 0, 0));

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].ld, vecs[i].c1, vecs[i].c2,
           vecs[i].din);
      check($sformatf("vec%0d data_out", i), bus.data_out, vecs[i].dout);
      check($sformatf("vec%0d locked", i), 16'(bus.locked), 16'(vecs[i].lk));
      check($sformatf("vec%0d streak", i), 16'(bus.streak), 16'(vecs[i].stk));
    end

    // Lock, then hold for several cycles regardless of en/data while cond1=1.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 1, 1, 8'(i));
    end
    check("seq lock_entry", 16'(bus.locked), 16'h1);
    check("seq lock_value", bus.data_out, 16'hCB67);
    for (int i = 0; i < 3; i++) begin
      step(1, 1'(i % 2), 0, 1, 1'(i % 2), 8'($urandom_range(255)));
      check($sformatf("seq hold%0d data_out", i), bus.data_out, 16'hCB67);
      check($sformatf("seq hold%0d locked", i), 16'(bus.locked), 16'h1);
    end
    // Exit with en=0: unlock still happens, no update.
    step(1, 0, 0, 0, 0, 8'h50);
    check("seq exit locked", 16'(bus.locked), 16'h0);
    check("seq exit streak", 16'(bus.streak), 16'h0);
    check("seq exit data_out", bus.data_out, 16'hCB67);
    step(1, 0, 0, 0, 0, 8'h50);
    check("seq en0 hold", bus.data_out, 16'hCB67);
    step(1, 1, 0, 0, 1, 8'h50);
    check("seq resume", bus.data_out, 16'h3C46);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
